ucapture16: RTL and testbench
=============================

UCAPTURE16 -- requirements
Module: ucapture16

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops on evt_in (legal values 2..4).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port areset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port enable  input  1  measurement enable; low forces IDLE.
REQ-005 SHALL provide port evt_in  input  1  asynchronous external event; rising edges delimit periods.
REQ-006 SHALL provide port capt_ack  input  1  consumer acknowledge of the captured value.
REQ-007 SHALL provide port capt_val  output  16  last captured period, in clk cycles.
REQ-008 SHALL provide port capt_valid  output  1  capt_val holds an unacknowledged capture.
REQ-009 SHALL provide port overflow  output  1  captured period exceeded 65535 cycles.
REQ-010 SHALL provide port lost  output  1  sticky; a capture was dropped while capt_valid was pending.
REQ-011 SHALL provide port dcount_top  output  16  live period counter value.

Function
REQ-012 SHALL pass evt_in through SYNC_STAGES flops, then one edge-detect flop; rise = synced & ~delayed.
REQ-013 rise SHALL take effect at the clk edge SYNC_STAGES edges after the edge that first samples evt_in high.
REQ-014 SHALL implement FSM states IDLE and MEASURE.
REQ-015 IDLE: counter = 0; on rise with enable=1 -> MEASURE, counter <= 1, no capture.
REQ-016 MEASURE: each edge without rise, counter increments by 1, saturating at 0xFFFF.
REQ-017 MEASURE: increment attempted at 0xFFFF SHALL set internal ovf flag; counter stays 0xFFFF.
REQ-018 MEASURE on rise: capture counter value (N for rises N edges apart), counter <= 1, ovf <= 0, stay MEASURE.
REQ-019 Capture SHALL load capt_val <= counter, overflow <= ovf, capt_valid <= 1, when capt_valid=0 or capt_ack=1 in that cycle.
REQ-020 Capture with capt_valid=1 and capt_ack=0 SHALL leave capt_val/overflow unchanged and set lost <= 1.
REQ-021 capt_ack=1 with no capture SHALL clear capt_valid and lost next edge; capt_val and overflow hold their values.
REQ-022 capt_ack coincident with capture SHALL result in capt_valid=1, new capt_val, and lost cleared.
REQ-023 capt_ack while capt_valid=0 SHALL have no effect.
REQ-024 capt_val and overflow SHALL be stable whenever capt_valid=1 except on an acknowledged-cycle capture.
REQ-025 enable=0 SHALL force IDLE, counter <= 0, ovf <= 0 at next edge; capture outputs and lost retain.
REQ-026 rise in the cycle enable falls SHALL be ignored (enable takes priority).
REQ-027 dcount_top SHALL equal the internal counter register (registered, no combinational path from inputs).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 areset=1 SHALL immediately, without clk, clear state to IDLE, counter, ovf, synchronizer and edge flops, capt_val, capt_valid, overflow, lost to 0.
REQ-030 After areset deasserts, first rise SHALL only arm MEASURE (no capture); evt_in held high through reset SHALL NOT produce a rise.
REQ-031 Reset mid-MEASURE SHALL discard the partial period.

Verification
REQ-032 areset pulse mid-MEASURE with capt_valid=1 -> all outputs 0 before next clk edge; state IDLE.
REQ-033 enable=1, evt_in rises 10 cycles apart, three times -> first rise no capture; capt_val=10, capt_valid=1, overflow=0; ack; second capture 10.
REQ-034 Rises 70000 cycles apart -> dcount_top holds 0xFFFF, capt_val=0xFFFF, overflow=1; next 20-cycle period -> capt_val=20, overflow=0.
REQ-035 Periods 5 then 7, no ack -> capt_val=5, lost=1; ack -> capt_valid=0, lost=0, capt_val=5.
REQ-036 capt_ack asserted in the exact capture cycle of a 12-cycle period while valid pending -> capt_valid=1, capt_val=12, lost=0.
REQ-037 enable dropped mid-period then re-raised -> counter 0 in IDLE; first subsequent rise no capture; next period measured exactly.

Source files
------------

// File: rtl/ucapture16.sv
// ucapture16 - period capture unit for an asynchronous event input.
//
// Measures the number of clk cycles between successive rising edges of evt_in
// and hands each measured period to a consumer through a valid/ack register.
//
// Ports:
//   clk         sole clock; all state updates on its rising edge
//   areset      asynchronous, active-high reset
//   enable      measurement enable; low returns the unit to IDLE
//   evt_in      asynchronous event input; rising edges delimit periods
//   capt_ack    consumer acknowledge of the captured value
//   capt_val    last captured period in clk cycles (saturates at 0xFFFF)
//   capt_valid  capt_val holds a capture the consumer has not yet acknowledged
//   overflow    the captured period exceeded 65535 cycles
//   lost        sticky; a capture was dropped while capt_valid was pending
//   dcount_top  live value of the period counter
//
// SYNC_STAGES selects the synchronizer depth; legal values are 2 to 4.

module ucapture16 #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        enable,
    input  logic        evt_in,
    input  logic        capt_ack,
    output logic [15:0] capt_val,
    output logic        capt_valid,
    output logic        overflow,
    output logic        lost,
    output logic [15:0] dcount_top
);

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE,
        MEASURE
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   delayed_q;
    logic                   seen_low_q;
    logic                   synced;
    logic                   rise;

    assign synced = sync_q[SYNC_STAGES-1];

    // prime_q tracks how far real samples have propagated into the chain after
    // reset. seen_low_q only sets once a genuinely sampled low reaches the end
    // of the chain, so an evt_in held high across reset never looks like an
    // edge against the reset-cleared flops.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_q     <= '0;
            prime_q    <= '0;
            delayed_q  <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], evt_in};
            prime_q   <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            delayed_q <= synced;
            if (prime_q[SYNC_STAGES-1] && !synced) begin
                seen_low_q <= 1'b1;
            end
        end
    end

    assign rise = synced & ~delayed_q & seen_low_q;

    // ------------------------------------------------------------------
    // Measurement FSM, counter and capture register
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [15:0] count_q;
    logic        ovf_q;
    logic        capture;
    logic        accept;

    // enable has priority over a coincident rise.
    assign capture = enable && (state_q == MEASURE) && rise;
    // A capture lands if the slot is free or is being freed in the same cycle.
    assign accept  = !capt_valid || capt_ack;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            capt_val   <= '0;
            capt_valid <= 1'b0;
            overflow   <= 1'b0;
            lost       <= 1'b0;
        end else begin
            // Consumer handshake. lost can only be set while capt_valid is
            // pending, so every accepted capture leaves it clear.
            if (capture) begin
                if (accept) begin
                    capt_val   <= count_q;
                    overflow   <= ovf_q;
                    capt_valid <= 1'b1;
                    lost       <= 1'b0;
                end else begin
                    lost <= 1'b1;
                end
            end else if (capt_ack) begin
                capt_valid <= 1'b0;
                lost       <= 1'b0;
            end

            // Period measurement.
            if (!enable) begin
                state_q <= IDLE;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        // The first edge only opens a period.
                        if (rise) begin
                            state_q <= MEASURE;
                            count_q <= 16'd1;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            count_q <= 16'd1;
                            ovf_q   <= 1'b0;
                        end else if (count_q == COUNT_MAX) begin
                            ovf_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dcount_top = count_q;

endmodule

// File: tb/tb_ucapture16.sv
// tb_ucapture16 - randomized, scoreboard-checked bench for ucapture16.
//
// The stimulus process drives evt_in pulses, enable and capt_ack, and keeps a
// period-level reference model: each pulse becomes effective SYNC_STAGES edges
// after it is sampled, and each period is the difference between the edge
// numbers of two effective rises. Accepted captures are queued; a separate
// monitor pops the queue whenever the DUT presents a new capture.

module tb_ucapture16;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable;
    logic        evt_in;
    logic        capt_ack;
    logic [15:0] capt_val;
    logic        capt_valid;
    logic        overflow;
    logic        lost;
    logic [15:0] dcount_top;

    always #5 clk = ~clk;

    ucapture16 #(
        .SYNC_STAGES(S)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .enable    (enable),
        .evt_in    (evt_in),
        .capt_ack  (capt_ack),
        .capt_val  (capt_val),
        .capt_valid(capt_valid),
        .overflow  (overflow),
        .lost      (lost),
        .dcount_top(dcount_top)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        int val;
        bit ovf;
    } cap_t;

    cap_t exp_q[$];
    int   pend[$];      // edge numbers at which sampled pulses become effective
    int   cyc = 0;      // number of rising clk edges so far
    bit   armed = 0;
    int   last_rise = 0;
    bit   exp_valid = 0;
    bit   exp_lost = 0;
    int   exp_val = 0;
    bit   exp_ovf = 0;
    bit   seen_low = 0;
    bit   evt_prev = 0;
    bit   en = 0;
    int   ack_mode = 0; // 0 none, 1 ack while valid, 2 random, 3 ack on capture edges

    function automatic int exp_count();
        int c;
        if (!armed) return 0;
        c = cyc - last_rise + 1;
        return (c > 65535) ? 65535 : c;
    endfunction

    task automatic model_edge(input bit ack);
        bit rise_now;
        bit cap;
        int period;
        int v;
        bit o;
        rise_now = (pend.size() > 0) && (pend[0] == cyc);
        if (rise_now) void'(pend.pop_front());
        cap    = 0;
        period = 0;
        if (!en) begin
            armed = 0;
        end else if (rise_now) begin
            if (!armed) begin
                armed     = 1;
                last_rise = cyc;
            end else begin
                period    = cyc - last_rise;
                last_rise = cyc;
                cap       = 1;
            end
        end
        if (cap) begin
            v = (period > 65535) ? 65535 : period;
            o = (period > 65535);
            if (!exp_valid || ack) begin
                exp_valid = 1;
                exp_lost  = 0;
                exp_val   = v;
                exp_ovf   = o;
                exp_q.push_back('{v, o});
            end else begin
                exp_lost = 1;
            end
        end else if (ack) begin
            exp_valid = 0;
            exp_lost  = 0;
        end
    endtask

    task automatic tick(input bit evt);
        bit ack;
        @(negedge clk);
        case (ack_mode)
            1:       ack = exp_valid;
            2:       ack = ($urandom_range(0, 3) == 0);
            3:       ack = (pend.size() > 0) && (pend[0] == cyc + 1);
            default: ack = 0;
        endcase
        evt_in   = evt;
        capt_ack = ack;
        enable   = en;
        if (evt && !evt_prev && seen_low) pend.push_back(cyc + 1 + S);
        if (!evt) seen_low = 1;
        evt_prev = evt;
        @(posedge clk);
        cyc++;
        model_edge(ack);
    endtask

    task automatic pulse(input int p);
        tick(1'b1);
        repeat (p - 1) tick(1'b0);
    endtask

    // Call only directly after tick or do_reset.
    task automatic check_state(input string name);
        #2;
        cmp({name, ".capt_valid"}, 32'(capt_valid), 32'(exp_valid));
        cmp({name, ".lost"},       32'(lost),       32'(exp_lost));
        cmp({name, ".capt_val"},   32'(capt_val),   32'(exp_val));
        cmp({name, ".overflow"},   32'(overflow),   32'(exp_ovf));
        cmp({name, ".dcount_top"}, 32'(dcount_top), 32'(exp_count()));
    endtask

    task automatic check_zero(input string name);
        cmp({name, ".capt_val"},   32'(capt_val),   32'd0);
        cmp({name, ".capt_valid"}, 32'(capt_valid), 32'd0);
        cmp({name, ".overflow"},   32'(overflow),   32'd0);
        cmp({name, ".lost"},       32'(lost),       32'd0);
        cmp({name, ".dcount_top"}, 32'(dcount_top), 32'd0);
    endtask

    // Asynchronous reset pulse: asserted mid-cycle, checked before the next edge.
    task automatic do_reset(input string name, input bit hold);
        @(negedge clk);
        capt_ack = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        check_zero(name);
        cmp({name, ".scoreboard_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        evt_in = hold;
        @(posedge clk);
        cyc++;
        @(posedge clk);
        cyc++;
        #2;
        areset    = 1'b0;
        pend.delete();
        armed     = 0;
        exp_valid = 0;
        exp_lost  = 0;
        exp_val   = 0;
        exp_ovf   = 0;
        seen_low  = 0;
        evt_prev  = hold;
    endtask

    // ------------------------------------------------------------------
    // Monitor: a new capture is visible when capt_valid rises, or stays high
    // across an edge at which capt_ack was asserted.
    // ------------------------------------------------------------------
    initial begin
        bit   prev;
        bit   ack_s;
        cap_t e;
        prev = 0;
        forever begin
            @(posedge clk);
            ack_s = capt_ack;
            #1;
            if (areset) begin
                prev = 0;
                continue;
            end
            if (capt_valid && (!prev || ack_s)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_capture: got capt_val=0x%0h, expected no capture (t=%0t)",
                             capt_val, $time);
                end else begin
                    e = exp_q.pop_front();
                    cmp("mon.capt_val", 32'(capt_val), 32'(e.val));
                    cmp("mon.overflow", 32'(overflow), 32'(e.ovf));
                    cmp("mon.lost",     32'(lost),     32'd0);
                end
            end
            prev = capt_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        areset   = 1'b0;
        enable   = 1'b0;
        evt_in   = 1'b0;
        capt_ack = 1'b0;
        #1;
        areset = 1'b1;
        #2;
        check_zero("reset");
        @(posedge clk);
        cyc++;
        @(posedge clk);
        cyc++;
        #2;
        areset = 1'b0;
        #1;
        check_zero("after_reset");

        // Three rises 10 apart: arm, capture 10, acknowledge, capture 10.
        en = 1;
        ack_mode = 0;
        repeat (6) tick(1'b0);
        pulse(10);
        pulse(10);
        check_state("first_capture");
        ack_mode = 1;
        pulse(10);
        check_state("second_capture");

        // Periods 5 then 7 without ack: second capture is lost.
        en = 0;
        repeat (2) tick(1'b0);
        check_state("disabled");
        en = 1;
        ack_mode = 0;
        repeat (2) tick(1'b0);
        pulse(5);
        pulse(7);
        pulse(6);
        check_state("lost_set");
        ack_mode = 1;
        tick(1'b0);
        check_state("lost_cleared");

        // Ack in the exact capture cycle while a capture is pending.
        en = 0;
        ack_mode = 0;
        repeat (2) tick(1'b0);
        en = 1;
        repeat (2) tick(1'b0);
        pulse(12);
        pulse(12);
        pulse(12);
        check_state("pending_lost");
        ack_mode = 3;
        pulse(12);
        ack_mode = 0;
        check_state("ack_at_capture");
        ack_mode = 1;
        tick(1'b0);
        ack_mode = 0;

        // Enable dropped mid-period, pulse while disabled, then re-enabled.
        tick(1'b1);
        repeat (3) tick(1'b0);
        en = 0;
        tick(1'b0);
        check_state("disabled_mid");
        tick(1'b1);
        repeat (6) tick(1'b0);
        en = 1;
        repeat (2) tick(1'b0);
        pulse(9);
        pulse(9);
        check_state("after_reenable");
        ack_mode = 1;
        tick(1'b0);
        ack_mode = 0;

        // Rise in the same cycle enable falls is ignored.
        tick(1'b1);
        repeat (S - 1) tick(1'b0);
        en = 0;
        tick(1'b0);
        en = 1;
        repeat (3) tick(1'b0);
        check_state("rise_on_disable");
        pulse(6);
        pulse(6);
        check_state("after_rise_on_disable");

        // 70000-cycle period saturates and flags overflow; next period clean.
        ack_mode = 1;
        pulse(70000);
        check_state("saturated");
        pulse(20);
        check_state("overflow_capture");
        pulse(20);
        check_state("after_overflow");

        // Reset mid-period with a capture pending.
        ack_mode = 0;
        pulse(8);
        repeat (3) tick(1'b0);
        check_state("pre_reset");
        do_reset("mid_measure_reset", 1'b0);
        check_state("post_reset");

        // evt_in held high through reset produces no rise.
        en = 1;
        repeat (6) tick(1'b0);
        do_reset("held_high_reset", 1'b1);
        repeat (10) tick(1'b1);
        check_state("held_high");
        repeat (8) tick(1'b0);
        pulse(8);
        pulse(8);
        check_state("after_held_high");

        // Randomized periods, acks and enable drops.
        ack_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                en = 0;
                repeat ($urandom_range(1, 3)) tick(1'b0);
                en = 1;
            end
            pulse(int'($urandom_range(2, 40)));
        end
        ack_mode = 1;
        repeat (50) tick(1'b0);
        check_state("final");
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
